clk_enable_gen: RTL and testbench

- Parametrised multi-channel fractional clock-enable generator. It is the fabric-side successor to the fixed-ratio PLL wrapper.
- Each channel is a phase accumulator (NCO). It emits one-cycle clock-enable pulses at f_clk*inc/2^ACC_W, so derived rates need no extra PLL output.
- Ratios and phase offsets can be reprogrammed at runtime. Channels can be realigned together with `sync`.
- A `locked` indicator mirrors PLL lock semantics for downstream reset sequencing.

---
 rtl/clk_enable_gen.sv | 124 ++++++++++++
 tb/tb_clk_enable_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator (NCO) per channel,
// runtime-reprogrammable ratio/phase, common realignment via sync, and a PLL-style lock flag.
module clk_enable_gen #(
  parameter int CHANNELS    = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 256,
  parameter bit GATE_CE     = 1'b0,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] phase_msb,
  output logic                locked
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0]  LOCK_MAX = LK_W'(LOCK_CYCLES);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

  // Writes addressing a non-existent channel are dropped entirely, including for lock.
  logic cfg_valid;
  assign cfg_valid = cfg_we && ({1'b0, cfg_sel} < CH_LIM);

  logic [CHANNELS-1:0] ce_raw;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_W-1:0] inc_reg;
      logic [ACC_W-1:0] phase_reg;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] acc_next;
      logic             en_reg;
      logic             ce_reg;
      logic             ce_next;
      logic             hit;
      logic [ACC_W:0]   sum;

      assign hit = cfg_valid && (cfg_sel == SEL_W'(gi));
      assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};

      // A write to this channel wins over sync, which wins over normal accumulation.
      always_comb begin
        acc_next = acc_reg;
        ce_next  = 1'b0;
        if (hit) begin
          acc_next = cfg_phase;
        end else if (sync) begin
          acc_next = phase_reg;
        end else if (en_reg) begin
          acc_next = sum[ACC_W-1:0];
          ce_next  = sum[ACC_W];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          inc_reg   <= '0;
          phase_reg <= '0;
          en_reg    <= 1'b0;
          acc_reg   <= '0;
          ce_reg    <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          ce_reg  <= ce_next;
          if (hit) begin
            inc_reg   <= cfg_inc;
            phase_reg <= cfg_phase;
            en_reg    <= cfg_en;
          end
        end
      end

      assign ce_raw[gi]    = ce_reg;
      assign phase_msb[gi] = acc_reg[ACC_W-1];
    end
  endgenerate

  logic [LK_W-1:0] cnt_reg;
  logic [LK_W-1:0] cnt_next;
  logic            locked_reg;
  logic            locked_next;

  // Any event that disturbs channel phase restarts the settle window.
  always_comb begin
    cnt_next    = cnt_reg;
    locked_next = locked_reg;
    if (cfg_valid || sync) begin
      cnt_next    = '0;
      locked_next = 1'b0;
    end else if (cnt_reg != LOCK_MAX) begin
      cnt_next    = cnt_reg + 1'b1;
      locked_next = (cnt_next == LOCK_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      locked_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      locked_reg <= locked_next;
    end
  end

  assign locked = locked_reg;

  generate
    if (GATE_CE) begin : g_gate
      assign ce = ce_raw & {CHANNELS{locked_reg}};
    end else begin : g_nogate
      assign ce = ce_raw;
    end
  endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: an ungated and a gated instance share all stimulus.
module tb_clk_enable_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_inc;
  logic [7:0] cfg_phase;
  logic       cfg_en;
  logic       sync;
  logic [2:0] ce, ce_g, msb, msb_g;
  logic       locked, locked_g;

  int errors = 0;
  int checks = 0;
  int pulses;
  int msb_seen;

  always #5 clk = ~clk;

  clk_enable_gen #(.CHANNELS(3), .ACC_W(8), .LOCK_CYCLES(16), .GATE_CE(1'b0)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase), .cfg_en(cfg_en), .sync(sync),
    .ce(ce), .phase_msb(msb), .locked(locked)
  );

  clk_enable_gen #(.CHANNELS(3), .ACC_W(8), .LOCK_CYCLES(16), .GATE_CE(1'b1)) u_dut_g (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase), .cfg_en(cfg_en), .sync(sync),
    .ce(ce_g), .phase_msb(msb_g), .locked(locked_g)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] sel, input logic [7:0] inc, input logic [7:0] ph,
                       input logic en);
    cfg_we = 1'b1; cfg_sel = sel; cfg_inc = inc; cfg_phase = ph; cfg_en = en;
    step();
    cfg_we = 1'b0;
    $display("write sel=%0d inc=%0d phase=%0d en=%0d -> ce=%b locked=%b", sel, inc, ph, en,
             ce, locked);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_inc = '0; cfg_phase = '0;
    cfg_en = 1'b0; sync = 1'b0;
    step();
    step();
    chk("rst_ce", 32'(ce), 32'(3'b000));
    chk("rst_msb", 32'(msb), 32'(3'b000));
    chk("rst_locked", 32'(locked), 32'(1'b0));
    chk("rst_ce_g", 32'(ce_g), 32'(3'b000));
    chk("rst_locked_g", 32'(locked_g), 32'(1'b0));
    reset = 1'b0;

    // Lock rises exactly 16 edges after the last reset edge.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("lock_after_reset", 32'(locked), 32'(k == 16));
    end

    write(2'd3, 8'd50, 8'd0, 1'b1);
    chk("invalid_wr_locked", 32'(locked), 32'(1'b1));
    chk("invalid_wr_ce", 32'(ce), 32'(3'b000));
    step();
    chk("invalid_wr_locked2", 32'(locked), 32'(1'b1));

    // inc=64: pulse every 4 edges, MSB 2 low / 2 high; relock 16 edges after the write.
    write(2'd0, 8'd64, 8'd0, 1'b1);
    chk("wr_unlock", 32'(locked), 32'(1'b0));
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("inc64_ce", 32'(ce[0]), 32'((k % 4) == 0));
      chk("inc64_msb", 32'(msb[0]), 32'((k % 4) >= 2));
      if (k >= 15) chk("inc64_relock", 32'(locked), 32'(k == 16));
    end

    // inc=96: pulses at edges 3, 6, 8 of every 8.
    write(2'd0, 8'd96, 8'd0, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("inc96_ce", 32'(ce[0]), 32'(((k % 8) == 3) || ((k % 8) == 6) || ((k % 8) == 0)));
      pulses += 32'(ce[0]);
    end
    chk("inc96_count", 32'(pulses), 32'd6);

    write(2'd0, 8'd0, 8'd0, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      pulses += $countones(ce);
    end
    chk("inc0_count", 32'(pulses), 32'd0);

    // Two channels half a turn apart, realigned by sync, alternate cycle by cycle.
    write(2'd0, 8'd128, 8'd0, 1'b1);
    write(2'd1, 8'd128, 8'd128, 1'b1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_ce", 32'(ce), 32'(3'b000));
    chk("sync_unlock", 32'(locked), 32'(1'b0));
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("alt_ce", 32'(ce[1:0]), 32'(((k % 2) == 1) ? 2'b10 : 2'b01));
    end

    // sync with a write to channel 1: channel 1 takes the new phase 0, so both coincide.
    sync = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_inc = 8'd128; cfg_phase = 8'd0;
    cfg_en = 1'b1;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    chk("sync_wr_ce", 32'(ce), 32'(3'b000));
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k <= 4) chk("sync_wr_align", 32'(ce[1:0]), 32'(((k % 2) == 0) ? 2'b11 : 2'b00));
    end
    chk("relock", 32'(locked), 32'(1'b1));
    chk("relock_g", 32'(locked_g), 32'(1'b1));

    // Channel 2 write drops lock: gated ce silent for 15 edges, MSB still runs.
    write(2'd2, 8'd64, 8'd0, 1'b1);
    chk("ch2_unlock", 32'(locked), 32'(1'b0));
    chk("ch2_unlock_g", 32'(locked_g), 32'(1'b0));
    chk("ch2_ce_g", 32'(ce_g), 32'(3'b000));
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) begin
        chk("gate_ce_g", 32'(ce_g), 32'(3'b000));
        chk("gate_ce_raw", 32'(ce[1:0]), 32'(((k % 2) == 1) ? 2'b11 : 2'b00));
        chk("gate_msb_g", 32'(msb_g[2]), 32'((k % 4) >= 2));
        chk("gate_locked_g", 32'(locked_g), 32'(1'b0));
      end else begin
        chk("gate_relock_g", 32'(locked_g), 32'(1'b1));
        chk("gate_open_ce_g", 32'(ce_g), 32'(3'b100));
      end
    end

    // Reset mid-stream clears everything, and nothing pulses until reconfigured.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_ce", 32'(ce), 32'(3'b000));
    chk("midrst_msb", 32'(msb), 32'(3'b000));
    chk("midrst_locked", 32'(locked), 32'(1'b0));
    chk("midrst_ce_g", 32'(ce_g), 32'(3'b000));
    chk("midrst_msb_g", 32'(msb_g), 32'(3'b000));
    pulses = 0;
    msb_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      pulses += $countones(ce) + $countones(ce_g);
      msb_seen += $countones(msb) + $countones(msb_g);
    end
    chk("midrst_no_ce", 32'(pulses), 32'd0);
    chk("midrst_no_msb", 32'(msb_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
